// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode map, funct7 patterns, ALU operation
// codes, immediate formats and the decoded bundle handed from decode to execute.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU opcode layout is {muldiv, alt, funct3}
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b01000;
    localparam logic [4:0] ALU_SRA = 5'b01101;
    localparam logic [4:0] ALU_MUL = 5'b10000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic        write_en;
        logic [4:0]  write_addr;
        logic [4:0]  read_addr1;
        logic [4:0]  read_addr2;
        logic [31:0] immediate;
        logic [4:0]  alu_opcode;
        logic        alu_src_imm;
        logic        mem_read_en;
        logic        mem_write_en;
        logic [2:0]  funct3;
        logic        branch_en;
        logic        jal_en;
        logic        jalr_en;
        logic        auipc_en;
        logic        illegal;
    } dec_bundle_t;

    // Sign-extended immediate for the given instruction format
    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'h000};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/inst_decode.sv
// Purely combinational RV32I(+M) instruction decoder. Illegal encodings come
// out with every enable and every operand field cleared, only funct3 and the
// illegal flag survive.
module inst_decode
    import rv_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]  inst_i,
    output dec_bundle_t  bundle_o
);

    logic [6:0] opcode_s;
    logic [6:0] funct7_s;
    logic [2:0] funct3_s;
    logic [4:0] rd_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    imm_fmt_e   fmt_s;
    logic [4:0] alu_op_s;
    logic       writes_s;
    logic       illegal_s;
    logic       rs1_zero_s;
    logic       src_imm_s;
    logic       mem_rd_s;
    logic       mem_wr_s;
    logic       branch_s;
    logic       jal_s;
    logic       jalr_s;
    logic       auipc_s;

    assign opcode_s = inst_i[6:0];
    assign rd_s     = inst_i[11:7];
    assign funct3_s = inst_i[14:12];
    assign rs1_s    = inst_i[19:15];
    assign rs2_s    = inst_i[24:20];
    assign funct7_s = inst_i[31:25];

    // Classify the opcode into controls, immediate format and legality
    always_comb begin
        fmt_s      = IMM_NONE;
        alu_op_s   = ALU_ADD;
        writes_s   = 1'b0;
        illegal_s  = 1'b0;
        rs1_zero_s = 1'b0;
        src_imm_s  = 1'b0;
        mem_rd_s   = 1'b0;
        mem_wr_s   = 1'b0;
        branch_s   = 1'b0;
        jal_s      = 1'b0;
        jalr_s     = 1'b0;
        auipc_s    = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                writes_s = 1'b1;
                if (ENABLE_M && (funct7_s == F7_MULDIV)) begin
                    alu_op_s = ALU_MUL | {2'b00, funct3_s};
                end else begin
                    alu_op_s = {1'b0, inst_i[30], funct3_s};
                end
                if (funct7_s == F7_BASE) begin
                    illegal_s = 1'b0;
                end else if ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
                    illegal_s = 1'b0;
                end else if (ENABLE_M && (funct7_s == F7_MULDIV)) begin
                    illegal_s = 1'b0;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                writes_s  = 1'b1;
                src_imm_s = 1'b1;
                fmt_s     = IMM_I;
                if (funct3_s == 3'b101) begin
                    // shift-right: bit 30 selects arithmetic vs logical
                    alu_op_s  = {1'b0, inst_i[30], funct3_s};
                    illegal_s = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
                end else if (funct3_s == 3'b001) begin
                    alu_op_s  = {2'b00, funct3_s};
                    illegal_s = (funct7_s != F7_BASE);
                end else begin
                    alu_op_s  = {2'b00, funct3_s};
                    illegal_s = 1'b0;
                end
            end
            OPC_LOAD: begin
                writes_s  = 1'b1;
                mem_rd_s  = 1'b1;
                src_imm_s = 1'b1;
                fmt_s     = IMM_I;
                illegal_s = (funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11);
            end
            OPC_STORE: begin
                mem_wr_s  = 1'b1;
                src_imm_s = 1'b1;
                fmt_s     = IMM_S;
                illegal_s = (funct3_s > 3'b010);
            end
            OPC_BRANCH: begin
                branch_s  = 1'b1;
                alu_op_s  = ALU_SUB;
                fmt_s     = IMM_B;
                illegal_s = (funct3_s[2:1] == 2'b01);
            end
            OPC_JAL: begin
                writes_s = 1'b1;
                jal_s    = 1'b1;
                fmt_s    = IMM_J;
            end
            OPC_JALR: begin
                writes_s  = 1'b1;
                jalr_s    = 1'b1;
                src_imm_s = 1'b1;
                fmt_s     = IMM_I;
                illegal_s = (funct3_s != 3'b000);
            end
            OPC_LUI: begin
                writes_s   = 1'b1;
                src_imm_s  = 1'b1;
                rs1_zero_s = 1'b1;
                fmt_s      = IMM_U;
            end
            OPC_AUIPC: begin
                writes_s  = 1'b1;
                auipc_s   = 1'b1;
                src_imm_s = 1'b1;
                fmt_s     = IMM_U;
            end
            OPC_MISC_MEM: begin
                illegal_s = 1'b0;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Assemble the bundle; an illegal encoding suppresses every side effect
    always_comb begin
        bundle_o        = '0;
        bundle_o.funct3 = funct3_s;
        if (illegal_s) begin
            bundle_o.illegal = 1'b1;
        end else begin
            bundle_o.write_en     = writes_s && (rd_s != 5'd0);
            bundle_o.write_addr   = rd_s;
            bundle_o.read_addr1   = rs1_zero_s ? 5'd0 : rs1_s;
            bundle_o.read_addr2   = rs2_s;
            bundle_o.immediate    = gen_imm(inst_i, fmt_s);
            bundle_o.alu_opcode   = alu_op_s;
            bundle_o.alu_src_imm  = src_imm_s;
            bundle_o.mem_read_en  = mem_rd_s;
            bundle_o.mem_write_en = mem_wr_s;
            bundle_o.branch_en    = branch_s;
            bundle_o.jal_en       = jal_s;
            bundle_o.jalr_en      = jalr_s;
            bundle_o.auipc_en     = auipc_s;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: one output register with
// a valid/ready handshake, flush, and synchronous reset around inst_decode.
// Only XLEN = 32 is supported in this generation.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN     = 32'd32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ip_inst,
    input  logic [XLEN-1:0] ip_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc,
    output logic            write_en,
    output logic [4:0]      write_addr,
    output logic [4:0]      read_addr1,
    output logic [4:0]      read_addr2,
    output logic [XLEN-1:0] immediate,
    output logic [4:0]      alu_opcode,
    output logic            alu_src_imm,
    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic [2:0]      funct3,
    output logic            branch_en,
    output logic            jal_en,
    output logic            jalr_en,
    output logic            auipc_en,
    output logic            illegal
);

    dec_bundle_t     dec_s;
    dec_bundle_t     bundle_d;
    dec_bundle_t     bundle_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;
    logic            valid_d;
    logic            valid_q;
    logic            accept_s;

    inst_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_inst_decode (
        .inst_i   (ip_inst),
        .bundle_o (dec_s)
    );

    // Flush keeps in_ready high so fetch can advance while the stage empties
    assign in_ready = flush || !valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Next state: flush clears, a transfer loads, a drain empties, else hold
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        pc_d     = pc_q;
        if (flush) begin
            valid_d  = 1'b0;
            bundle_d = '0;
            pc_d     = '0;
        end else if (accept_s) begin
            valid_d  = 1'b1;
            bundle_d = dec_s;
            pc_d     = ip_pc;
        end else if (out_ready) begin
            valid_d  = 1'b0;
        end else begin
            valid_d  = valid_q;
        end
    end

    // Output register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
        end
    end

    assign out_valid    = valid_q;
    assign pc           = pc_q;
    assign write_en     = bundle_q.write_en;
    assign write_addr   = bundle_q.write_addr;
    assign read_addr1   = bundle_q.read_addr1;
    assign read_addr2   = bundle_q.read_addr2;
    assign immediate    = bundle_q.immediate;
    assign alu_opcode   = bundle_q.alu_opcode;
    assign alu_src_imm  = bundle_q.alu_src_imm;
    assign mem_read_en  = bundle_q.mem_read_en;
    assign mem_write_en = bundle_q.mem_write_en;
    assign funct3       = bundle_q.funct3;
    assign branch_en    = bundle_q.branch_en;
    assign jal_en       = bundle_q.jal_en;
    assign jalr_en      = bundle_q.jalr_en;
    assign auipc_en     = bundle_q.auipc_en;
    assign illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: two instances (RV32M on / off) share
// the same stimulus; directed scenarios plus a randomized handshake run
// checked against a queue-based reference model.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic        write_en;
        logic [4:0]  write_addr;
        logic [4:0]  read_addr1;
        logic [4:0]  read_addr2;
        logic [31:0] immediate;
        logic [4:0]  alu_opcode;
        logic        alu_src_imm;
        logic        mem_read_en;
        logic        mem_write_en;
        logic [2:0]  funct3;
        logic        branch_en;
        logic        jal_en;
        logic        jalr_en;
        logic        auipc_en;
        logic        illegal;
    } bundle_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } txn_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] ip_inst, ip_pc;

    logic        in_ready_m, out_valid_m, write_en_m, alu_src_imm_m, mem_read_en_m, mem_write_en_m;
    logic        branch_en_m, jal_en_m, jalr_en_m, auipc_en_m, illegal_m;
    logic [31:0] pc_m, immediate_m;
    logic [4:0]  write_addr_m, read_addr1_m, read_addr2_m, alu_opcode_m;
    logic [2:0]  funct3_m;

    logic        in_ready_n, out_valid_n, write_en_n, alu_src_imm_n, mem_read_en_n, mem_write_en_n;
    logic        branch_en_n, jal_en_n, jalr_en_n, auipc_en_n, illegal_n;
    logic [31:0] pc_n, immediate_n;
    logic [4:0]  write_addr_n, read_addr1_n, read_addr2_n, alu_opcode_n;
    logic [2:0]  funct3_n;

    bundle_t got_m, got_n;
    assign got_m = {pc_m, write_en_m, write_addr_m, read_addr1_m, read_addr2_m, immediate_m,
                    alu_opcode_m, alu_src_imm_m, mem_read_en_m, mem_write_en_m, funct3_m,
                    branch_en_m, jal_en_m, jalr_en_m, auipc_en_m, illegal_m};
    assign got_n = {pc_n, write_en_n, write_addr_n, read_addr1_n, read_addr2_n, immediate_n,
                    alu_opcode_n, alu_src_imm_n, mem_read_en_n, mem_write_en_n, funct3_n,
                    branch_en_n, jal_en_n, jalr_en_n, auipc_en_n, illegal_n};

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) dut_m (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
        .ip_inst(ip_inst), .ip_pc(ip_pc), .out_valid(out_valid_m), .out_ready(out_ready),
        .pc(pc_m), .write_en(write_en_m), .write_addr(write_addr_m), .read_addr1(read_addr1_m),
        .read_addr2(read_addr2_m), .immediate(immediate_m), .alu_opcode(alu_opcode_m),
        .alu_src_imm(alu_src_imm_m), .mem_read_en(mem_read_en_m), .mem_write_en(mem_write_en_m),
        .funct3(funct3_m), .branch_en(branch_en_m), .jal_en(jal_en_m), .jalr_en(jalr_en_m),
        .auipc_en(auipc_en_m), .illegal(illegal_m)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) dut_n (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .ip_inst(ip_inst), .ip_pc(ip_pc), .out_valid(out_valid_n), .out_ready(out_ready),
        .pc(pc_n), .write_en(write_en_n), .write_addr(write_addr_n), .read_addr1(read_addr1_n),
        .read_addr2(read_addr2_n), .immediate(immediate_n), .alu_opcode(alu_opcode_n),
        .alu_src_imm(alu_src_imm_n), .mem_read_en(mem_read_en_n), .mem_write_en(mem_write_en_n),
        .funct3(funct3_n), .branch_en(branch_en_n), .jal_en(jal_en_n), .jalr_en(jalr_en_n),
        .auipc_en(auipc_en_n), .illegal(illegal_n)
    );

    // Reference decoder: immediates via signed shifts, legality from the ISA rules
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv, input bit en_m);
        bundle_t     b;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        bit          legal, writes, uses_rs1;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        imm_i = $signed(ins) >>> 20;
        imm_s = $signed({ins[31:25], ins[11:7], 20'd0}) >>> 20;
        imm_b = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 20'd0}) >>> 19;
        imm_u = ins & 32'hFFFF_F000;
        imm_j = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 12'd0}) >>> 11;
        b = '0; b.pc = pcv; b.funct3 = f3;
        legal = 1'b1; writes = 1'b0; uses_rs1 = 1'b1;
        case (opc)
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && en_m);
                writes = 1'b1;
                b.alu_opcode = (f7 == 7'h01) ? {2'b10, f3} : {1'b0, ins[30], f3};
            end
            7'h13: begin
                legal = !((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20));
                writes = 1'b1; b.alu_src_imm = 1'b1; b.immediate = imm_i;
                b.alu_opcode = {1'b0, (f3 == 3'd5) && ins[30], f3};
            end
            7'h03: begin
                legal = !(f3 inside {3'd3, 3'd6, 3'd7});
                writes = 1'b1; b.mem_read_en = 1'b1; b.alu_src_imm = 1'b1; b.immediate = imm_i;
            end
            7'h23: begin
                legal = (f3 <= 3'd2);
                b.mem_write_en = 1'b1; b.alu_src_imm = 1'b1; b.immediate = imm_s;
            end
            7'h63: begin
                legal = !(f3 inside {3'd2, 3'd3});
                b.branch_en = 1'b1; b.alu_opcode = 5'b01000; b.immediate = imm_b;
            end
            7'h6F: begin writes = 1'b1; b.jal_en = 1'b1; b.immediate = imm_j; end
            7'h67: begin
                legal = (f3 == 3'd0);
                writes = 1'b1; b.jalr_en = 1'b1; b.alu_src_imm = 1'b1; b.immediate = imm_i;
            end
            7'h37: begin writes = 1'b1; b.alu_src_imm = 1'b1; b.immediate = imm_u; uses_rs1 = 1'b0; end
            7'h17: begin writes = 1'b1; b.auipc_en = 1'b1; b.alu_src_imm = 1'b1; b.immediate = imm_u; end
            7'h0F: begin legal = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            b = '0; b.pc = pcv; b.funct3 = f3; b.illegal = 1'b1;
        end else begin
            b.write_addr = ins[11:7];
            b.read_addr1 = uses_rs1 ? ins[19:15] : 5'd0;
            b.read_addr2 = ins[24:20];
            b.write_en   = writes && (ins[11:7] != 5'd0);
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;  9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73;
            default: w[6:0] = w[6:0];
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: w[31:25] = w[31:25];
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pcv);
        in_valid = 1'b1; ip_inst = inst; ip_pc = pcv; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ip_inst = 32'h0; ip_pc = 32'h0;
        repeat (3) tick();
        checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid_m); end
        checks++; if (got_m !== '0) begin errors++; $display("FAIL reset_payload_m got=%h exp=0", got_m); end
        checks++; if (got_n !== '0) begin errors++; $display("FAIL reset_payload_n got=%h exp=0", got_n); end
        reset = 1'b0;
        tick();
        checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_m); end
    endtask

    task automatic test_alu();
        present(32'h00500093, 32'h0000_0100);  // ADDI x1,x0,5
        checks++; if (out_valid_m !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", out_valid_m); end
        checks++;
        if ({write_en_m, write_addr_m, immediate_m, alu_opcode_m, alu_src_imm_m, illegal_m} !== {1'b1, 5'd1, 32'd5, 5'b00000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL addi_fields got we=%b rd=%0d imm=%h op=%b src=%b ill=%b", write_en_m, write_addr_m, immediate_m, alu_opcode_m, alu_src_imm_m, illegal_m);
        end
        checks++; if (pc_m !== 32'h0000_0100) begin errors++; $display("FAIL addi_pc got=%h exp=00000100", pc_m); end
        present(32'h4030D113, 32'h0000_0104);  // SRAI x2,x1,3
        checks++;
        if ({alu_opcode_m, immediate_m[4:0], read_addr1_m, write_addr_m} !== {5'b01101, 5'd3, 5'd1, 5'd2}) begin
            errors++; $display("FAIL srai_fields got op=%b sh=%0d rs1=%0d rd=%0d", alu_opcode_m, immediate_m[4:0], read_addr1_m, write_addr_m);
        end
        present(32'h00000013, 32'h0000_0108);  // ADDI x0,x0,0
        checks++; if ({write_en_m, illegal_m, out_valid_m} !== 3'b001) begin errors++; $display("FAIL nop_we got we/ill/v=%b exp=001", {write_en_m, illegal_m, out_valid_m}); end
        tick();
    endtask

    task automatic test_mem_branch();
        present(32'h0020A423, 32'h0000_0200);  // SW x2,8(x1)
        checks++;
        if ({mem_write_en_m, immediate_m, write_en_m, mem_read_en_m} !== {1'b1, 32'd8, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sw_fields got mw=%b imm=%h we=%b mr=%b", mem_write_en_m, immediate_m, write_en_m, mem_read_en_m);
        end
        present(32'hFE208EE3, 32'h0000_0204);  // BEQ x1,x2,-4
        checks++;
        if ({branch_en_m, immediate_m, alu_opcode_m, write_en_m} !== {1'b1, 32'hFFFF_FFFC, 5'b01000, 1'b0}) begin
            errors++; $display("FAIL beq_fields got br=%b imm=%h op=%b we=%b", branch_en_m, immediate_m, alu_opcode_m, write_en_m);
        end
        tick();
    endtask

    task automatic test_muldiv();
        present(32'h022081B3, 32'h0000_0300);  // MUL x3,x1,x2
        checks++;
        if ({alu_opcode_m, write_en_m, illegal_m} !== {5'b10000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mul_m got op=%b we=%b ill=%b", alu_opcode_m, write_en_m, illegal_m);
        end
        checks++;
        if ({illegal_n, write_en_n, out_valid_n} !== 3'b101) begin
            errors++; $display("FAIL mul_n got ill/we/v=%b exp=101", {illegal_n, write_en_n, out_valid_n});
        end
        tick();
    endtask

    task automatic test_back_pressure();
        bundle_t exp_a, exp_b;
        exp_a = ref_decode(32'h00700293, 32'h0000_0400, 1'b1);  // ADDI x5,x0,7
        exp_b = ref_decode(32'h00628333, 32'h0000_0404, 1'b1);  // ADD x6,x5,x6
        present(32'h00700293, 32'h0000_0400);
        in_valid = 1'b1; ip_inst = 32'h00628333; ip_pc = 32'h0000_0404; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready_m !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, in_ready_m); end
            checks++; if (out_valid_m !== 1'b1 || got_m !== exp_a) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, got_m, exp_a); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid_m !== 1'b1 || got_m !== exp_b) begin errors++; $display("FAIL bp_release got=%h exp=%h", got_m, exp_b); end
        tick();
        checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", out_valid_m); end
    endtask

    task automatic test_flush();
        present(32'h00500093, 32'h0000_0500);
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; ip_inst = 32'h00A00113; ip_pc = 32'h0000_0504;
        #1;
        checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready_m); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid_m); end
        tick();
        checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b exp=0", out_valid_m); end
    endtask

    task automatic test_reset_midstream();
        present(32'hFE208EE3, 32'h0000_0600);
        reset = 1'b1; in_valid = 1'b1; ip_inst = 32'h00500093; ip_pc = 32'h0000_0604;
        tick();
        checks++; if (out_valid_m !== 1'b0 || got_m !== '0) begin errors++; $display("FAIL midreset got v=%b p=%h exp 0", out_valid_m, got_m); end
        reset = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin errors++; $display("FAIL midreset_after got v=%b rdy=%b exp 0/1", out_valid_m, in_ready_m); end
    endtask

    task automatic test_random();
        txn_t q[$];
        txn_t t;
        logic exp_ready;
        bundle_t exp_m, exp_n;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ip_inst   = rand_inst();
            ip_pc     = $urandom & 32'hFFFF_FFFC;
            #1;
            exp_ready = (q.size() == 0) || out_ready;
            checks++;
            if (in_ready_m !== exp_ready || in_ready_n !== exp_ready) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b", cyc, in_ready_m, in_ready_n, exp_ready);
            end
            checks++;
            if (out_valid_m !== (q.size() != 0) || out_valid_n !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", cyc, out_valid_m, out_valid_n, q.size() != 0);
            end
            if (q.size() != 0) begin
                exp_m = ref_decode(q[0].inst, q[0].pc, 1'b1);
                exp_n = ref_decode(q[0].inst, q[0].pc, 1'b0);
                checks++;
                if (got_m !== exp_m) begin errors++; $display("FAIL rnd_payload_m cyc=%0d inst=%h got=%h exp=%h", cyc, q[0].inst, got_m, exp_m); end
                checks++;
                if (got_n !== exp_n) begin errors++; $display("FAIL rnd_payload_n cyc=%0d inst=%h got=%h exp=%h", cyc, q[0].inst, got_n, exp_n); end
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_ready) begin
                t.inst = ip_inst; t.pc = ip_pc;
                q.push_back(t);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_branch();
        test_muldiv();
        test_back_pressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction-decode stage with a valid/ready handshake on both sides.
- Sits between fetch and execute in the pipelined core.
- Decodes the full RV32I base opcode set, plus RV32M when enabled, into register-file, immediate, ALU and memory/branch controls.
- Flags illegal encodings and supports a pipeline flush.

Parameters:
- XLEN, 32, datapath/immediate/PC width; only 32 is legal in this generation.
- ENABLE_M, 0, 1 = decode OP funct7=0000001 as multiply/divide; 0 = report it as illegal.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard the held and the incoming instruction
- in_valid  input  1  ip_inst/ip_pc valid
- in_ready  output  1  stage can accept this cycle
- ip_inst  input  32  instruction word
- ip_pc  input  XLEN  PC of ip_inst
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts bundle
- pc  output  XLEN  registered ip_pc
- write_en  output  1  register write; forced 0 when rd==x0
- write_addr, read_addr1, read_addr2  output  5 each  rd, rs1, rs2
- immediate  output  XLEN  sign-extended immediate per format
- alu_opcode  output  5  {muldiv, alt, funct3}
- alu_src_imm  output  1  ALU operand B = immediate
- mem_read_en, mem_write_en  output  1 each  load / store
- funct3  output  3  ip_inst[14:12]
- branch_en, jal_en, jalr_en, auipc_en  output  1 each  control-flow / PC-relative select
- illegal  output  1  illegal encoding

Behaviour:
- Reset: out_valid=0 and every payload output=0. in_ready=1 from the cycle after reset deasserts.
- Single output register: in_ready = !out_valid || out_ready (combinational).
- Transfer: in_valid && in_ready captures the decoded bundle at the edge; out_valid=1 the next cycle. Latency is 1 cycle.
- Throughput: 1/cycle when out_ready stays high.
- Hold: while out_valid && !out_ready, the payload is held stable and in_ready=0.
- Flush (and reset) has priority over everything: out_valid=0 next cycle, and an input presented in the flush cycle is dropped. in_ready is still 1 during flush, so fetch may advance.
- Immediate formats:
  - I: {20{i31},i[31:20]}
  - S: {20{i31},i[31:25],i[11:7]}
  - B: {19{i31},i31,i7,i[30:25],i[11:8],0}
  - U: {i[31:12],12'h0}
  - J: {11{i31},i31,i[19:12],i20,i[30:21],0}
  - R-type: immediate=0.
- Opcode map (alu_opcode = {m,a,f3}):
  - OP (0110011): a=i30, m=0; or m=1, a=0 for RV32M.
  - OP-IMM (0010011): alu_src_imm=1; a=i30 only when f3=101, else a=0.
  - LOAD (0000011): ADD, mem_read_en, write_en.
  - STORE (0100011): ADD, mem_write_en, no write.
  - BRANCH (1100011): alu_opcode=01000 (SUB), branch_en, no write.
  - JAL (1101111): jal_en, write_en, J-imm.
  - JALR (1100111): jalr_en, write_en, I-imm, ADD.
  - LUI (0110111): ADD, read_addr1 forced 0, alu_src_imm.
  - AUIPC (0010111): auipc_en, alu_src_imm, ADD.
  - MISC-MEM (0001111): legal NOP with all enables 0.
- Illegal = 1 for any of:
  - an unlisted opcode, including SYSTEM 1110011;
  - LOAD f3 in {011,110,111};
  - STORE f3 > 010;
  - BRANCH f3 in {010,011};
  - JALR f3 != 000;
  - OP funct7 not 0000000, not 0100000 with f3 in {000,101}, and not (0000001 with ENABLE_M=1);
  - OP-IMM f3=001 with funct7 != 0;
  - OP-IMM f3=101 with funct7 not in {0000000,0100000}.
- Illegal bundles still handshake normally, with every enable (write/mem/branch/jal/jalr/auipc) =0.
- No X on any output at any time; don't-care fields drive 0.

Decomposition:
- Shared package rv_pkg holds the opcode localparams, ALU opcode constants (ALU_ADD=5'b00000, ALU_SUB=5'b01000, ALU_SRA=5'b01101, ALU_MUL=5'b10000) and the immediate-format enum.
- One combinational sub-module, inst_decode, maps ip_inst to the bundle.
- decode_stage adds the handshake, flush and output register around inst_decode.

Test Plan:
- ADDI x1,x0,5 (0x00500093), in_valid=1, out_ready=1 -> next cycle out_valid=1, write_en=1, write_addr=1, immediate=5, alu_opcode=00000, alu_src_imm=1, illegal=0.
- SRAI x2,x1,3 (0x4030D113) -> alu_opcode=01101, immediate[4:0]=3, read_addr1=1; ADDI x0,x0,0 (0x00000013) -> write_en=0.
- SW x2,8(x1) (0x0020A423) -> mem_write_en=1, immediate=8, write_en=0; BEQ x1,x2,-4 (0xFE208EE3) -> branch_en=1, immediate=0xFFFFFFFC, alu_opcode=01000.
- MUL x3,x1,x2 (0x022081B3): ENABLE_M=1 -> alu_opcode=10000, write_en=1; ENABLE_M=0 -> illegal=1, write_en=0, out_valid=1.
- Back-pressure: with out_ready=0 for 3 cycles after a capture -> in_ready=0 and payload unchanged; out_ready=1 -> the next instruction appears one cycle later with none lost or duplicated.
- Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle and the input is dropped; reset asserted mid-stream -> out_valid=0 and all outputs 0 at the next edge.
